// File: rtl/serial_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM encodings,
// default frame geometry and the idle line level.
package serial_pkg;

    localparam int unsigned SERIAL_WORD_SIZE      = 4;
    localparam int unsigned SERIAL_CLOCKS_PER_BIT = 16;

    localparam logic LINE_IDLE = 1'b1;

    typedef logic [2:0] serial_state_t;

    localparam serial_state_t IDLE  = 3'd0;
    localparam serial_state_t FETCH = 3'd1;
    localparam serial_state_t LOAD  = 3'd2;
    localparam serial_state_t START = 3'd3;
    localparam serial_state_t DATA  = 3'd4;
    localparam serial_state_t STOP  = 3'd5;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Free-running bit-period timer; tick marks the last cycle of each bit.
module bit_period_counter
    import serial_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = SERIAL_CLOCKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = width_of(CLOCKS_PER_BIT);
    localparam logic [CntW-1:0] LastCount = CntW'(CLOCKS_PER_BIT - 1);

    logic [CntW-1:0] count_q, count_d;

    assign tick = (count_q == LastCount);

    // Advance, wrapping after the last cycle of the period; clear holds at 0.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Timer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_serial_transmitter.sv
// Drains a word FIFO and sends each word as start bit, LSB-first data, stop bit.
module fifo_serial_transmitter
    import serial_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = SERIAL_WORD_SIZE,
    parameter int unsigned CLOCKS_PER_BIT = SERIAL_CLOCKS_PER_BIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [WORD_SIZE-1:0] fifo_data,
    output logic                 fifo_read_enable,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IdxW = width_of(WORD_SIZE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_SIZE - 1);

    serial_state_t        state_q, state_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 timer_clear;

    // Timer only runs while a frame is on the line, so START always begins at 0.
    assign timer_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

    bit_period_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_period_counter (
        .clock(clock),
        .reset(reset),
        .clear(timer_clear),
        .tick (tick)
    );

    // FSM, shift register and bit index next-state logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO data_out is valid the cycle after the strobe.
                shift_d = fifo_data;
                idx_d   = '0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LastIdx) begin
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = fifo_empty ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx changes with the state.
    always_comb begin
        case (state_d)
            START:   tx_d = ~LINE_IDLE;
            DATA:    tx_d = shift_d[0];
            default: tx_d = LINE_IDLE;
        endcase
    end

    // State and line registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign fifo_read_enable = (state_q == FETCH);
    assign busy             = (state_q != IDLE);
    assign tx               = tx_q;

endmodule

// File: tb/tb_fifo_serial_transmitter.sv
// Bench for fifo_serial_transmitter: default instance plus a 2-clock-per-bit
// instance, each fed by a small behavioural FIFO.
module tb_fifo_serial_transmitter;

    localparam int LogMax = 400;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    logic [1:0] rd_en, empty, tx_w, busy_w;
    logic [3:0] fdata [2];
    logic [3:0] mem [2][64];
    int wr_ptr [2];
    int rd_ptr [2];
    int strobes [2];
    int underflow [2];

    assign empty[0] = (rd_ptr[0] == wr_ptr[0]);
    assign empty[1] = (rd_ptr[1] == wr_ptr[1]);

    // Behavioural FIFOs: registered data_out, reset by the same signal as the DUTs.
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                rd_ptr[d] <= wr_ptr[d];
            end else if (rd_en[d]) begin
                strobes[d] <= strobes[d] + 1;
                if (rd_ptr[d] == wr_ptr[d]) begin
                    underflow[d] <= underflow[d] + 1;
                end else begin
                    fdata[d]  <= mem[d][rd_ptr[d] % 64];
                    rd_ptr[d] <= rd_ptr[d] + 1;
                end
            end
        end
    end

    fifo_serial_transmitter dut (
        .clock           (clock),
        .reset           (reset),
        .fifo_empty      (empty[0]),
        .fifo_data       (fdata[0]),
        .fifo_read_enable(rd_en[0]),
        .tx              (tx_w[0]),
        .busy            (busy_w[0])
    );

    fifo_serial_transmitter #(
        .WORD_SIZE     (4),
        .CLOCKS_PER_BIT(2)
    ) dut_fast (
        .clock           (clock),
        .reset           (reset),
        .fifo_empty      (empty[1]),
        .fifo_data       (fdata[1]),
        .fifo_read_enable(rd_en[1]),
        .tx              (tx_w[1]),
        .busy            (busy_w[1])
    );

    typedef struct {
        logic [3:0] word;
        logic [5:0] levels;  // bit k = line level during bit period k
    } vec_t;

    vec_t vecs [5];

    int vectors = 0;
    int miscompares = 0;

    logic tx_log [LogMax];
    logic busy_log [LogMax];
    logic rd_log [LogMax];
    int n_log;

    int nf;
    int starts [8];
    int gaps [8];
    logic [3:0] words [8];

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input int d, input logic [3:0] w);
        mem[d][wr_ptr[d] % 64] = w;
        wr_ptr[d] = wr_ptr[d] + 1;
    endtask

    task automatic log_run(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            tx_log[i]   = tx_w[d];
            busy_log[i] = busy_w[d];
            rd_log[i]   = rd_en[d];
        end
        n_log = n;
    endtask

    task automatic tally(output int tx_low, output int busy_cnt, output int rd_cnt,
                         output int first_rd, output int first_low, output int last_busy);
        tx_low = 0; busy_cnt = 0; rd_cnt = 0;
        first_rd = -1; first_low = -1; last_busy = -1;
        for (int i = 0; i < n_log; i++) begin
            if (tx_log[i] !== 1'b1) begin
                tx_low++;
                if (first_low < 0) first_low = i;
            end
            if (busy_log[i] === 1'b1) begin
                busy_cnt++;
                last_busy = i;
            end
            if (rd_log[i] === 1'b1) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = i;
            end
        end
    endtask

    // Split the logged line into frames: decode mid-bit samples, measure idle gaps.
    task automatic analyze(input int cpb);
        int i;
        int j;
        int s;
        logic [3:0] w;
        for (int f = 0; f < 8; f++) begin
            starts[f] = -1;
            gaps[f]   = -1;
            words[f]  = 4'h0;
        end
        nf = 0;
        i  = 0;
        while (i < n_log && nf < 8) begin
            if (tx_log[i] === 1'b0) begin
                s = i;
                w = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    if (s + cpb * (k + 1) + cpb / 2 < n_log) begin
                        w[k] = tx_log[s + cpb * (k + 1) + cpb / 2];
                    end
                end
                starts[nf] = s;
                words[nf]  = w;
                j = s + 5 * cpb;
                while (j < n_log && tx_log[j] === 1'b1) j++;
                gaps[nf] = (j < n_log) ? j - (s + 5 * cpb) : -1;
                nf++;
                i = (j > i) ? j : i + 1;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        int tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy, bad;

        vecs[0] = '{word: 4'b1011, levels: 6'b110110};
        vecs[1] = '{word: 4'h0,    levels: 6'b100000};
        vecs[2] = '{word: 4'hF,    levels: 6'b111110};
        vecs[3] = '{word: 4'h6,    levels: 6'b101100};
        vecs[4] = '{word: 4'h9,    levels: 6'b110010};

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_tx", int'(tx_w[0]), 1);
        check("reset_busy", int'(busy_w[0]), 0);
        check("reset_rd", int'(rd_en[0]), 0);
        reset = 1'b0;

        // Empty FIFO: line idles, no strobe.
        log_run(0, 200);
        tally(tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy);
        check("idle_tx_low_cycles", tx_low, 0);
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_strobes", rd_cnt, 0);

        // Single-word frames from the table.
        for (int v = 0; v < 5; v++) begin
            push(0, vecs[v].word);
            log_run(0, 110);
            tally(tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy);
            check($sformatf("v%0d_strobes", v), rd_cnt, 1);
            check($sformatf("v%0d_strobe_lead", v), first_low - first_rd, 2);
            bad = 0;
            for (int k = 0; k < 110; k++) begin
                if (first_low < 0 || first_low + k >= n_log) begin
                    bad++;
                end else if (k < 96) begin
                    if (tx_log[first_low + k] !== vecs[v].levels[k / 16]) bad++;
                end else if (tx_log[first_low + k] !== 1'b1) begin
                    bad++;
                end
                if (first_low >= 0 && first_low + k + 1 >= n_log) break;
            end
            check($sformatf("v%0d_line_errors", v), bad, 0);
            check($sformatf("v%0d_busy_cycles", v), busy_cnt, 98);
            analyze(16);
            check($sformatf("v%0d_decoded", v), int'(words[0]), int'(vecs[v].word));
        end

        // Three queued words go out back-to-back, then the line returns to idle.
        push(0, 4'h3);
        push(0, 4'hC);
        push(0, 4'h5);
        log_run(0, 320);
        tally(tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy);
        analyze(16);
        check("b2b_strobes", rd_cnt, 3);
        check("b2b_frames", nf, 3);
        check("b2b_word0", int'(words[0]), 4'h3);
        check("b2b_word1", int'(words[1]), 4'hC);
        check("b2b_word2", int'(words[2]), 4'h5);
        check("b2b_gap0", gaps[0], 18);
        check("b2b_gap1", gaps[1], 18);
        check("b2b_busy_cycles", busy_cnt, 294);
        check("b2b_busy_fall", last_busy, starts[2] + 95);
        check("b2b_end_busy", int'(busy_log[n_log - 1]), 0);

        // Reset in the middle of the data bits of 4'hA.
        push(0, 4'hA);
        log_run(0, 40);
        check("mid_frame_busy", int'(busy_log[39]), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_reset_tx", int'(tx_w[0]), 1);
        check("mid_reset_busy", int'(busy_w[0]), 0);
        check("mid_reset_rd", int'(rd_en[0]), 0);
        reset = 1'b0;
        log_run(0, 150);
        tally(tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy);
        check("post_reset_tx_low_cycles", tx_low, 0);
        check("post_reset_busy_cycles", busy_cnt, 0);
        check("post_reset_strobes", rd_cnt, 0);

        // Two clocks per bit: 12-cycle frame, timer and index wrap.
        push(1, 4'b1011);
        log_run(1, 30);
        tally(tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy);
        check("fast_strobes", rd_cnt, 1);
        check("fast_strobe_lead", first_low - first_rd, 2);
        check("fast_frame_len", last_busy - first_low + 1, 12);
        check("fast_busy_cycles", busy_cnt, 14);
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            if (first_low < 0 || first_low + k >= n_log) begin
                bad++;
            end else if (k < 12) begin
                if (tx_log[first_low + k] !== vecs[0].levels[k / 2]) bad++;
            end else if (tx_log[first_low + k] !== 1'b1) begin
                bad++;
            end
        end
        check("fast_line_errors", bad, 0);

        push(1, 4'h3);
        push(1, 4'hC);
        log_run(1, 50);
        tally(tx_low, busy_cnt, rd_cnt, first_rd, first_low, last_busy);
        analyze(2);
        check("fast_b2b_strobes", rd_cnt, 2);
        check("fast_b2b_frames", nf, 2);
        check("fast_b2b_word0", int'(words[0]), 4'h3);
        check("fast_b2b_word1", int'(words[1]), 4'hC);
        check("fast_b2b_gap", gaps[0], 4);

        check("underflow_default", underflow[0], 0);
        check("underflow_fast", underflow[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
